ni_packet_engine: RTL and testbench
===================================

# ni_packet_engine

Parametrised network interface that replaces the fixed 16-bit packetizer/FIFO/de-packetizer path with a configurable one. The TX side turns a stream of local data words into head/body/tail flits, stamps them with source and destination addresses, and buffers them in an internal FIFO toward the router. The RX side accepts flits from the router, filters them by node address, and strips them back to data words, flagging end-of-packet and protocol errors. Both directions use valid/ready handshakes.

## Interface
- DATA_W, 16: payload bits per flit and per data word; must be at least 2*ADDR_W+LEN_W.
- ADDR_W, 4: node address width.
- MAX_LEN, 8: maximum number of payload words per packet. LEN_W = $clog2(MAX_LEN+1).
- DEPTH, 8: TX FIFO depth in flits; must be a power of 2, at least 2.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- node_addr  in  ADDR_W  this node's address; used as TX src and as the RX match value.
- tx_start  in  1  request a new packet; sampled only in TX IDLE.
- tx_dest  in  ADDR_W  destination address; sampled with tx_start.
- tx_len  in  LEN_W  payload word count, 1..MAX_LEN; sampled with tx_start.
- tx_busy  out  1  TX FSM is not in IDLE.
- tx_data  in  DATA_W  payload word.
- tx_data_valid  in  1  tx_data is valid.
- tx_data_ready  out  1  word accepted when valid and ready are both high.
- net_tx_flit  out  DATA_W+2  FIFO head flit.
- net_tx_valid  out  1  FIFO not empty.
- net_tx_ready  in  1  router accepts the flit.
- net_rx_flit  in  DATA_W+2  incoming flit.
- net_rx_valid  in  1  incoming flit is valid.
- net_rx_ready  out  1  RX accepts the flit.
- rx_data  out  DATA_W  depacketized word.
- rx_src  out  ADDR_W  source address of the current packet.
- rx_valid  out  1  rx_data is valid.
- rx_packet_end  out  1  rx_data is the last word of its packet; valid only with rx_valid.
- rx_out_ready  in  1  consumer accepts rx_data.
- rx_err_count  out  8  count of protocol errors; saturates at 255.

## Operation
- Flit format is {type[1:0], payload[DATA_W-1:0]}. Type codes: 01 head, 10 body, 11 tail, 00 invalid.
- Head payload is {zeros, len, dest, src}, with src in bits [ADDR_W-1:0].
- A packet of len words is one head flit followed by len flits. All but the last are body flits; the last is a tail flit. When len=1 the packet is head then tail.
- **TX FSM, IDLE → HEAD:**
  - IDLE: on tx_start, if tx_len is 0 or greater than MAX_LEN, ignore the request and increment rx_err_count (shared error counter). Otherwise latch dest and len and go to HEAD.
  - HEAD: push the head flit when the FIFO is not full, then go to PAYLOAD.
- **TX FSM, PAYLOAD → IDLE:**
  - tx_data_ready = PAYLOAD and FIFO not full, combinational.
  - Each accepted word is pushed as body or tail and the remaining count is decremented.
  - After the tail is pushed, go to IDLE.
- **TX FIFO:**
  - Circular buffer with read/write pointers one bit wider than log2(DEPTH); pointers wrap.
  - A simultaneous push and pop while full is permitted: the pop frees the slot in the same cycle.
  - A simultaneous push and pop while empty is not a bypass; the pushed flit is visible on the next cycle.
- **RX FSM, WAIT_HEAD:**
  - net_rx_ready = 1.
  - A non-head flit is dropped and increments the error counter.
  - A head flit with dest == node_addr latches src and len and goes to PAYLOAD.
  - A head flit with dest != node_addr latches len and goes to DROP.
- **RX FSM, PAYLOAD:**
  - net_rx_ready = !rx_valid || rx_out_ready.
  - Each accepted flit loads rx_data, sets rx_valid, and sets rx_packet_end on the last word.
  - If a flit's type disagrees with the expected type (body vs tail, by remaining count), deliver it anyway, force rx_packet_end=1, increment the error counter, and return to WAIT_HEAD.
  - Otherwise return to WAIT_HEAD after the expected tail.
- **RX FSM, DROP:** net_rx_ready = 1; consume len flits silently, then return to WAIT_HEAD.
- **Error counter:** if the TX and RX sides report an error in the same cycle, it increments by 2, saturating at 255.

## Timing
- **Reset values:** both FSMs in IDLE/WAIT_HEAD, FIFO empty, net_tx_valid=0, tx_busy=0, tx_data_ready=0, rx_valid=0, rx_packet_end=0, rx_data=0, rx_src=0, rx_err_count=0.
- **Reset mid-packet:** the partial packet is discarded and the FIFO contents are lost.
- **TX latency:**
  - tx_start in IDLE (cycle 0) → HEAD in cycle 1.
  - Head flit written at the end of cycle 1 → net_tx_valid high in cycle 2.
  - First word can be accepted in cycle 2.
- **TX throughput:** one flit per cycle when the FIFO is not full.
- **Back-to-back TX:** tx_start may be accepted the cycle after the tail is pushed.
- **RX latency:** flit accepted in cycle N → rx_valid high in cycle N+1, registered.
- **RX throughput:** one word per cycle while rx_out_ready=1.
- **RX hold:** rx_valid stays high, and rx_data and rx_packet_end stay stable, until rx_out_ready.
- **Net-side hold:** net_tx_flit must stay stable while net_tx_valid && !net_tx_ready.

## Test plan
- **Single TX packet:** node_addr=2, tx_start with dest=5, len=3, words A1,A2,A3, net_tx_ready=1 → flits {01,..0352}, {10,A1}, {10,A2}, {11,A3}; tx_busy falls after the tail.
- **FIFO backpressure:** DEPTH=8, net_tx_ready=0, len=8 → 8 flits accepted, then tx_data_ready=0 and net_tx_valid=1. Releasing net_tx_ready drains all 9 flits in order with no loss or duplication.
- **RX match:** node_addr=5, inject the head for dest=5, src=2, len=2, then body B1 and tail B2 → rx_data B1 (end=0), then B2 (end=1), with rx_src=2 throughout.
- **RX filter:** head with dest=3 and len=2, followed by the matching packet from the previous test → the first packet's 2 flits are swallowed, only B1/B2 are delivered, and rx_err_count=0.
- **Errors:**
  - A stray body flit in WAIT_HEAD increments rx_err_count.
  - A tail arriving where a body is expected is delivered with rx_packet_end=1 and the count increments.
  - tx_len=0 is ignored and the count increments.
  - Saturation at 255 holds.
- **Reset mid-packet, plus output stall:** assert reset during TX PAYLOAD → FIFO empty and tx_busy=0 after reset. Hold rx_out_ready=0 for 5 cycles → rx_data stays stable and net_rx_ready=0.

Source files
------------

// File: rtl/ni_packet_engine.sv
// Network interface packet engine.
// TX: local data words -> head/body/tail flits, buffered in a FIFO toward the router.
// RX: router flits -> filtered by node address -> data words with end-of-packet marking.
module ni_packet_engine #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] node_addr_i,
    // TX request and payload
    input  logic              tx_start_i,
    input  logic [ADDR_W-1:0] tx_dest_i,
    input  logic [LEN_W-1:0]  tx_len_i,
    output logic              tx_busy_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_data_valid_i,
    output logic              tx_data_ready_o,
    // Router side, outbound
    output logic [DATA_W+1:0] net_tx_flit_o,
    output logic              net_tx_valid_o,
    input  logic              net_tx_ready_i,
    // Router side, inbound
    input  logic [DATA_W+1:0] net_rx_flit_i,
    input  logic              net_rx_valid_i,
    output logic              net_rx_ready_o,
    // Local RX output
    output logic [DATA_W-1:0] rx_data_o,
    output logic [ADDR_W-1:0] rx_src_o,
    output logic              rx_valid_o,
    output logic              rx_packet_end_o,
    input  logic              rx_out_ready_i,
    output logic [7:0]        rx_err_count_o
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FLIT_W = DATA_W + 2;

    localparam logic [1:0] TypeHead = 2'b01;
    localparam logic [1:0] TypeBody = 2'b10;
    localparam logic [1:0] TypeTail = 2'b11;

    localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LenOne = LEN_W'(1);

    typedef enum logic [1:0] {TxIdle, TxHead, TxPayload} tx_state_e;
    typedef enum logic [1:0] {RxWaitHead, RxPayload, RxDrop} rx_state_e;

    // ---------------------------------------------------------------------------------------
    // TX FIFO
    // ---------------------------------------------------------------------------------------
    logic [FLIT_W-1:0] fifo_mem_q [DEPTH];
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic              fifo_empty, fifo_full, fifo_pop, fifo_push, fifo_space;
    logic [FLIT_W-1:0] fifo_wdata;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign fifo_pop   = !fifo_empty && net_tx_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
    assign fifo_space = !fifo_full || fifo_pop;

    assign net_tx_valid_o = !fifo_empty;
    assign net_tx_flit_o  = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];

    // Pointer next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (fifo_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (fifo_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk_i) begin
        if (fifo_push) fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= fifo_wdata;
    end

    // ---------------------------------------------------------------------------------------
    // TX FSM
    // ---------------------------------------------------------------------------------------
    tx_state_e         tx_state_q, tx_state_d;
    logic [ADDR_W-1:0] tx_dest_q, tx_dest_d;
    logic [LEN_W-1:0]  tx_rem_q, tx_rem_d;
    logic              tx_err;
    logic [DATA_W-1:0] head_payload;

    // Head payload layout: {zeros, len, dest, src}. tx_rem_q still holds len while in HEAD.
    always_comb begin
        head_payload = '0;
        head_payload[ADDR_W-1:0]         = node_addr_i;
        head_payload[ADDR_W +: ADDR_W]   = tx_dest_q;
        head_payload[2*ADDR_W +: LEN_W]  = tx_rem_q;
    end

    // TX next-state, FIFO push and handshake outputs.
    always_comb begin
        tx_state_d      = tx_state_q;
        tx_dest_d       = tx_dest_q;
        tx_rem_d        = tx_rem_q;
        tx_err          = 1'b0;
        tx_data_ready_o = 1'b0;
        fifo_push       = 1'b0;
        fifo_wdata      = '0;
        unique case (tx_state_q)
            TxIdle: begin
                if (tx_start_i) begin
                    if (tx_len_i == '0 || tx_len_i > MaxLen) begin
                        tx_err = 1'b1;
                    end else begin
                        tx_dest_d  = tx_dest_i;
                        tx_rem_d   = tx_len_i;
                        tx_state_d = TxHead;
                    end
                end
            end
            TxHead: begin
                if (fifo_space) begin
                    fifo_push  = 1'b1;
                    fifo_wdata = {TypeHead, head_payload};
                    tx_state_d = TxPayload;
                end
            end
            TxPayload: begin
                tx_data_ready_o = fifo_space;
                if (tx_data_valid_i && fifo_space) begin
                    fifo_push  = 1'b1;
                    fifo_wdata = {(tx_rem_q == LenOne) ? TypeTail : TypeBody, tx_data_i};
                    tx_rem_d   = tx_rem_q - 1'b1;
                    if (tx_rem_q == LenOne) tx_state_d = TxIdle;
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    assign tx_busy_o = (tx_state_q != TxIdle);

    // TX state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_state_q <= TxIdle;
            tx_dest_q  <= '0;
            tx_rem_q   <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_dest_q  <= tx_dest_d;
            tx_rem_q   <= tx_rem_d;
        end
    end

    // ---------------------------------------------------------------------------------------
    // RX FSM
    // ---------------------------------------------------------------------------------------
    rx_state_e         rx_state_q, rx_state_d;
    logic [LEN_W-1:0]  rx_rem_q, rx_rem_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [ADDR_W-1:0] rx_src_q, rx_src_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_end_q, rx_end_d;
    logic              rx_err, rx_fire;
    logic [1:0]        rx_type;
    logic [DATA_W-1:0] rx_payload;
    logic [ADDR_W-1:0] hdr_src, hdr_dest;
    logic [LEN_W-1:0]  hdr_len;

    assign rx_type    = net_rx_flit_i[FLIT_W-1 -: 2];
    assign rx_payload = net_rx_flit_i[DATA_W-1:0];
    assign hdr_src    = rx_payload[ADDR_W-1:0];
    assign hdr_dest   = rx_payload[ADDR_W +: ADDR_W];
    assign hdr_len    = rx_payload[2*ADDR_W +: LEN_W];
    assign rx_fire    = net_rx_valid_i && net_rx_ready_o;

    // RX next-state, output register loading and error detection.
    always_comb begin
        rx_state_d     = rx_state_q;
        rx_rem_d       = rx_rem_q;
        rx_data_d      = rx_data_q;
        rx_src_d       = rx_src_q;
        rx_valid_d     = rx_valid_q && !rx_out_ready_i;
        rx_end_d       = rx_end_q;
        rx_err         = 1'b0;
        net_rx_ready_o = 1'b1;
        unique case (rx_state_q)
            RxWaitHead: begin
                if (rx_fire) begin
                    // A zero-length head has no payload to follow; treat it as malformed.
                    if (rx_type != TypeHead || hdr_len == '0) begin
                        rx_err = 1'b1;
                    end else if (hdr_dest == node_addr_i) begin
                        rx_src_d   = hdr_src;
                        rx_rem_d   = hdr_len;
                        rx_state_d = RxPayload;
                    end else begin
                        rx_rem_d   = hdr_len;
                        rx_state_d = RxDrop;
                    end
                end
            end
            RxPayload: begin
                net_rx_ready_o = !rx_valid_q || rx_out_ready_i;
                if (rx_fire) begin
                    rx_data_d  = rx_payload;
                    rx_valid_d = 1'b1;
                    rx_rem_d   = rx_rem_q - 1'b1;
                    if (rx_rem_q == LenOne && rx_type == TypeTail) begin
                        rx_end_d   = 1'b1;
                        rx_state_d = RxWaitHead;
                    end else if (rx_rem_q != LenOne && rx_type == TypeBody) begin
                        rx_end_d = 1'b0;
                    end else begin
                        // Unexpected type: hand the word over but close the packet.
                        rx_end_d   = 1'b1;
                        rx_err     = 1'b1;
                        rx_state_d = RxWaitHead;
                    end
                end
            end
            RxDrop: begin
                if (rx_fire) begin
                    rx_rem_d = rx_rem_q - 1'b1;
                    if (rx_rem_q == LenOne) rx_state_d = RxWaitHead;
                end
            end
            default: rx_state_d = RxWaitHead;
        endcase
    end

    // RX state and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_state_q <= RxWaitHead;
            rx_rem_q   <= '0;
            rx_data_q  <= '0;
            rx_src_q   <= '0;
            rx_valid_q <= 1'b0;
            rx_end_q   <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_rem_q   <= rx_rem_d;
            rx_data_q  <= rx_data_d;
            rx_src_q   <= rx_src_d;
            rx_valid_q <= rx_valid_d;
            rx_end_q   <= rx_end_d;
        end
    end

    assign rx_data_o       = rx_data_q;
    assign rx_src_o        = rx_src_q;
    assign rx_valid_o      = rx_valid_q;
    assign rx_packet_end_o = rx_end_q;

    // ---------------------------------------------------------------------------------------
    // Shared saturating error counter
    // ---------------------------------------------------------------------------------------
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [8:0] err_sum;

    // TX and RX errors in the same cycle both count.
    always_comb begin
        err_sum   = {1'b0, err_cnt_q} + {8'd0, tx_err} + {8'd0, rx_err};
        err_cnt_d = (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
    end

    // Error counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) err_cnt_q <= '0;
        else       err_cnt_q <= err_cnt_d;
    end

    assign rx_err_count_o = err_cnt_q;

endmodule

// File: tb/tb_ni_packet_engine.sv
// Directed self-checking bench for ni_packet_engine with default parameters.
module tb_ni_packet_engine;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [3:0]  node_addr_i = '0;
    logic        tx_start_i = 1'b0;
    logic [3:0]  tx_dest_i = '0;
    logic [3:0]  tx_len_i = '0;
    logic        tx_busy_o;
    logic [15:0] tx_data_i = '0;
    logic        tx_data_valid_i = 1'b0;
    logic        tx_data_ready_o;
    logic [17:0] net_tx_flit_o;
    logic        net_tx_valid_o;
    logic        net_tx_ready_i = 1'b1;
    logic [17:0] net_rx_flit_i = '0;
    logic        net_rx_valid_i = 1'b0;
    logic        net_rx_ready_o;
    logic [15:0] rx_data_o;
    logic [3:0]  rx_src_o;
    logic        rx_valid_o;
    logic        rx_packet_end_o;
    logic        rx_out_ready_i = 1'b1;
    logic [7:0]  rx_err_count_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [17:0] tx_seen [$];
    logic [31:0] rx_seen [$];

    ni_packet_engine dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .node_addr_i     (node_addr_i),
        .tx_start_i      (tx_start_i),
        .tx_dest_i       (tx_dest_i),
        .tx_len_i        (tx_len_i),
        .tx_busy_o       (tx_busy_o),
        .tx_data_i       (tx_data_i),
        .tx_data_valid_i (tx_data_valid_i),
        .tx_data_ready_o (tx_data_ready_o),
        .net_tx_flit_o   (net_tx_flit_o),
        .net_tx_valid_o  (net_tx_valid_o),
        .net_tx_ready_i  (net_tx_ready_i),
        .net_rx_flit_i   (net_rx_flit_i),
        .net_rx_valid_i  (net_rx_valid_i),
        .net_rx_ready_o  (net_rx_ready_o),
        .rx_data_o       (rx_data_o),
        .rx_src_o        (rx_src_o),
        .rx_valid_o      (rx_valid_o),
        .rx_packet_end_o (rx_packet_end_o),
        .rx_out_ready_i  (rx_out_ready_i),
        .rx_err_count_o  (rx_err_count_o)
    );

    initial forever #5 clk_i = ~clk_i;

    // Record every flit the router takes and every word the consumer takes.
    always @(posedge clk_i) begin
        if (!rst_i && net_tx_valid_o && net_tx_ready_i) tx_seen.push_back(net_tx_flit_o);
        if (!rst_i && rx_valid_o && rx_out_ready_i)
            rx_seen.push_back({11'd0, rx_packet_end_o, rx_src_o, rx_data_o});
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Offer one payload word and wait (bounded) for the handshake.
    task automatic send_word(input logic [15:0] w);
        int n = 0;
        tx_data_i       = w;
        tx_data_valid_i = 1'b1;
        forever begin
            #1;
            if (tx_data_ready_o) break;
            if (n >= 50) begin
                check_eq("tx_data_ready_timeout", {31'd0, tx_data_ready_o}, 32'd1);
                tx_data_valid_i = 1'b0;
                return;
            end
            n++;
            step();
        end
        step();
        tx_data_valid_i = 1'b0;
    endtask

    // Offer one flit from the router and wait (bounded) for the handshake.
    task automatic send_flit(input logic [17:0] f);
        int n = 0;
        net_rx_flit_i  = f;
        net_rx_valid_i = 1'b1;
        forever begin
            #1;
            if (net_rx_ready_o) break;
            if (n >= 50) begin
                check_eq("net_rx_ready_timeout", {31'd0, net_rx_ready_o}, 32'd1);
                net_rx_valid_i = 1'b0;
                return;
            end
            n++;
            step();
        end
        step();
        net_rx_valid_i = 1'b0;
    endtask

    task automatic start_packet(input logic [3:0] dest, input logic [3:0] len);
        tx_dest_i  = dest;
        tx_len_i   = len;
        tx_start_i = 1'b1;
        step();
        tx_start_i = 1'b0;
    endtask

    task automatic check_tx_seen(input string tag, input logic [17:0] exp [$]);
        check_eq({tag, "_count"}, tx_seen.size(), exp.size());
        for (int i = 0; i < exp.size() && i < tx_seen.size(); i++)
            check_eq($sformatf("%s_flit%0d", tag, i), {14'd0, tx_seen[i]}, {14'd0, exp[i]});
    endtask

    task automatic check_rx_seen(input string tag, input logic [31:0] exp [$]);
        check_eq({tag, "_count"}, rx_seen.size(), exp.size());
        for (int i = 0; i < exp.size() && i < rx_seen.size(); i++)
            check_eq($sformatf("%s_word%0d", tag, i), rx_seen[i], exp[i]);
    endtask

    initial begin
        logic [17:0] exp_tx [$];
        logic [31:0] exp_rx [$];

        // Reset state
        repeat (2) step();
        rst_i = 1'b0;
        #1;
        check_eq("rst_tx_busy", {31'd0, tx_busy_o}, 32'd0);
        check_eq("rst_net_tx_valid", {31'd0, net_tx_valid_o}, 32'd0);
        check_eq("rst_tx_data_ready", {31'd0, tx_data_ready_o}, 32'd0);
        check_eq("rst_rx_valid", {31'd0, rx_valid_o}, 32'd0);
        check_eq("rst_rx_end", {31'd0, rx_packet_end_o}, 32'd0);
        check_eq("rst_rx_data", {16'd0, rx_data_o}, 32'd0);
        check_eq("rst_rx_src", {28'd0, rx_src_o}, 32'd0);
        check_eq("rst_err", {24'd0, rx_err_count_o}, 32'd0);
        check_eq("rst_net_rx_ready", {31'd0, net_rx_ready_o}, 32'd1);

        // Single TX packet: src 2, dest 5, len 3
        node_addr_i = 4'd2;
        step();
        start_packet(4'd5, 4'd3);
        #1;
        check_eq("tx1_busy", {31'd0, tx_busy_o}, 32'd1);
        send_word(16'h00A1);
        send_word(16'h00A2);
        send_word(16'h00A3);
        #1;
        check_eq("tx1_busy_after_tail", {31'd0, tx_busy_o}, 32'd0);
        repeat (4) step();
        exp_tx = '{{2'b01, 16'h0352}, {2'b10, 16'h00A1}, {2'b10, 16'h00A2},
                   {2'b11, 16'h00A3}};
        check_tx_seen("tx1", exp_tx);

        // FIFO backpressure: head + 7 words fill the 8-deep FIFO
        tx_seen.delete();
        net_tx_ready_i = 1'b0;
        start_packet(4'd5, 4'd8);
        for (int i = 0; i < 7; i++) send_word(16'hD000 + 16'(i));
        tx_data_i       = 16'hD007;
        tx_data_valid_i = 1'b1;
        repeat (3) begin
            step();
            check_eq("bp_data_ready_full", {31'd0, tx_data_ready_o}, 32'd0);
            check_eq("bp_net_tx_valid", {31'd0, net_tx_valid_o}, 32'd1);
        end
        net_tx_ready_i = 1'b1;
        send_word(16'hD007);
        repeat (12) step();
        exp_tx = '{{2'b01, 16'h0852}};
        for (int i = 0; i < 7; i++) exp_tx.push_back({2'b10, 16'hD000 + 16'(i)});
        exp_tx.push_back({2'b11, 16'hD007});
        check_tx_seen("bp", exp_tx);
        check_eq("bp_drained", {31'd0, net_tx_valid_o}, 32'd0);

        // RX match: node 5 receives from src 2, len 2
        node_addr_i = 4'd5;
        rx_seen.delete();
        send_flit({2'b01, 16'h0252});
        send_flit({2'b10, 16'h00B1});
        send_flit({2'b11, 16'h00B2});
        repeat (3) step();
        exp_rx = '{{11'd0, 1'b0, 4'd2, 16'h00B1}, {11'd0, 1'b1, 4'd2, 16'h00B2}};
        check_rx_seen("rxm", exp_rx);

        // RX filter: packet for dest 3 is swallowed, then the matching packet arrives
        rx_seen.delete();
        send_flit({2'b01, 16'h0232});
        send_flit({2'b10, 16'hDEAD});
        send_flit({2'b11, 16'hBEEF});
        send_flit({2'b01, 16'h0252});
        send_flit({2'b10, 16'h00B1});
        send_flit({2'b11, 16'h00B2});
        repeat (3) step();
        check_rx_seen("rxf", exp_rx);
        check_eq("rxf_err", {24'd0, rx_err_count_o}, 32'd0);

        // Errors
        rx_seen.delete();
        send_flit({2'b10, 16'h1234});
        check_eq("err_stray_body", {24'd0, rx_err_count_o}, 32'd1);
        send_flit({2'b01, 16'h0252});
        send_flit({2'b11, 16'h00C1});
        repeat (2) step();
        check_eq("err_early_tail", {24'd0, rx_err_count_o}, 32'd2);
        exp_rx = '{{11'd0, 1'b1, 4'd2, 16'h00C1}};
        check_rx_seen("err_tail", exp_rx);
        start_packet(4'd1, 4'd0);
        check_eq("err_len0", {24'd0, rx_err_count_o}, 32'd3);
        check_eq("err_len0_idle", {31'd0, tx_busy_o}, 32'd0);
        // TX and RX errors in the same cycle
        net_rx_flit_i  = {2'b10, 16'h5555};
        net_rx_valid_i = 1'b1;
        start_packet(4'd1, 4'd0);
        net_rx_valid_i = 1'b0;
        check_eq("err_both", {24'd0, rx_err_count_o}, 32'd5);
        start_packet(4'd1, 4'd9);
        check_eq("err_len_over", {24'd0, rx_err_count_o}, 32'd6);
        // Saturation
        net_rx_flit_i  = {2'b10, 16'h5555};
        net_rx_valid_i = 1'b1;
        repeat (300) step();
        net_rx_valid_i = 1'b0;
        check_eq("err_saturate", {24'd0, rx_err_count_o}, 32'd255);

        // Reset mid-packet
        net_tx_ready_i = 1'b0;
        start_packet(4'd1, 4'd4);
        send_word(16'h0EEE);
        check_eq("mid_busy", {31'd0, tx_busy_o}, 32'd1);
        check_eq("mid_net_tx_valid", {31'd0, net_tx_valid_o}, 32'd1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        #1;
        check_eq("mid_rst_net_tx_valid", {31'd0, net_tx_valid_o}, 32'd0);
        check_eq("mid_rst_busy", {31'd0, tx_busy_o}, 32'd0);
        check_eq("mid_rst_err", {24'd0, rx_err_count_o}, 32'd0);
        tx_seen.delete();
        net_tx_ready_i = 1'b1;
        repeat (3) step();
        check_eq("mid_rst_no_flits", tx_seen.size(), 32'd0);

        // Output stall
        rx_seen.delete();
        rx_out_ready_i = 1'b0;
        send_flit({2'b01, 16'h0252});
        send_flit({2'b10, 16'h00E1});
        net_rx_flit_i  = {2'b11, 16'h00E2};
        net_rx_valid_i = 1'b1;
        repeat (5) begin
            step();
            check_eq("stall_valid", {31'd0, rx_valid_o}, 32'd1);
            check_eq("stall_data", {16'd0, rx_data_o}, 32'h00E1);
            check_eq("stall_end", {31'd0, rx_packet_end_o}, 32'd0);
            check_eq("stall_net_rx_ready", {31'd0, net_rx_ready_o}, 32'd0);
        end
        rx_out_ready_i = 1'b1;
        send_flit({2'b11, 16'h00E2});
        repeat (3) step();
        exp_rx = '{{11'd0, 1'b0, 4'd2, 16'h00E1}, {11'd0, 1'b1, 4'd2, 16'h00E2}};
        check_rx_seen("stall", exp_rx);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
